// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: streams two operands LSB-first through one 1-bit
// full-add cell with a registered carry, behind a start/busy/done handshake.

module full_add_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out
);
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sa, sb, ss, ss_next;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;
  logic             accept, last;

  full_add_cell u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .c_in (cy),
    .s    (fa_s),
    .c_out(fa_co)
  );

  // DONE accepts a new request exactly like IDLE, giving back-to-back operation.
  assign accept  = start && ((state == IDLE) || (state == DONE));
  assign last    = (state == RUN) && (cnt == LAST);
  assign ss_next = (ss >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The result registers load on the same edge that processes the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa      <= '0;
      sb      <= '0;
      ss      <= '0;
      cy      <= 1'b0;
      cnt     <= '0;
      sum_out <= '0;
      c_out   <= 1'b0;
    end else if (accept) begin
      sa  <= a_in;
      sb  <= b_in;
      cy  <= c_in;
      cnt <= '0;
      ss  <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      ss  <= ss_next;
      cy  <= fa_co;
      cnt <= cnt + CW'(1);
      if (last) begin
        sum_out <= ss_next;
        c_out   <= fa_co;
      end
    end
  end
endmodule
